// File: rtl/mac_unit_dbw.sv
// Systolic-array MAC processing element: forwards ifmap/weights to neighbours and
// accumulates ifmap*weight onto the upstream partial sum with double-buffered weights.
module mac_unit_dbw #(
  parameter int unsigned WD  = 8,
  parameter int unsigned PW  = 2 * WD,
  parameter int unsigned SAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [WD-1:0] ifmap_in,
  input  logic          ifmap_vld_in,
  input  logic [WD-1:0] wght_in,
  input  logic          load_wght,
  input  logic          swap_wght,
  input  logic [PW-1:0] psum_in,
  input  logic          clr_ovf,
  output logic [WD-1:0] ifmap_out,
  output logic          ifmap_vld_out,
  output logic [WD-1:0] wght_out,
  output logic [PW-1:0] psum_out,
  output logic          psum_vld_out,
  output logic          ovf
);

  localparam int unsigned PRW = 2 * WD;
  localparam int unsigned SW  = PW + 1;
  localparam logic [PW-1:0] PMAX = {1'b0, {(PW - 1){1'b1}}};
  localparam logic [PW-1:0] PMIN = {1'b1, {(PW - 1){1'b0}}};

  if (PW < 2 * WD) begin : g_pw_check
    $error("mac_unit_dbw: PW must be at least 2*WD");
  end

  logic [WD-1:0] ifmap_q, ifmap_d;
  logic          ifmap_vld_q, ifmap_vld_d;
  logic [WD-1:0] shadow_q, shadow_d;
  logic [WD-1:0] active_q, active_d;
  logic [PW-1:0] psum_q, psum_d;
  logic          psum_vld_q, psum_vld_d;
  logic          ovf_q, ovf_d;

  logic signed [PRW-1:0] ifmap_ext_c;
  logic signed [PRW-1:0] active_ext_c;
  logic signed [PRW-1:0] prod_c;
  logic signed [SW-1:0]  psum_ext_c;
  logic signed [SW-1:0]  prod_ext_c;
  logic signed [SW-1:0]  sum_c;
  logic                  sum_ovf_c;
  logic [PW-1:0]         result_c;

  // Datapath: one guard bit above PW is enough since |product| <= 2^(PW-2).
  always_comb begin
    ifmap_ext_c  = {{WD{ifmap_q[WD-1]}}, ifmap_q};
    active_ext_c = {{WD{active_q[WD-1]}}, active_q};
    prod_c       = ifmap_ext_c * active_ext_c;
    psum_ext_c   = {psum_in[PW-1], psum_in};
    prod_ext_c   = {{(SW - PRW){prod_c[PRW-1]}}, prod_c};
    sum_c        = psum_ext_c + prod_ext_c;
    sum_ovf_c    = sum_c[SW-1] ^ sum_c[SW-2];
    result_c     = sum_c[PW-1:0];
    if (sum_ovf_c && (SAT != 0)) begin
      result_c = sum_c[SW-1] ? PMIN : PMAX;
    end
  end

  // Next-state: swap reads the pre-edge shadow, so load+swap moves the old weight.
  always_comb begin
    ifmap_d     = ifmap_in;
    ifmap_vld_d = ifmap_vld_in;
    shadow_d    = shadow_q;
    active_d    = active_q;
    psum_d      = psum_q;
    psum_vld_d  = 1'b0;
    ovf_d       = ovf_q;
    if (load_wght) begin
      shadow_d = wght_in;
    end
    if (swap_wght) begin
      active_d = shadow_q;
    end
    if (ifmap_vld_q) begin
      psum_d     = result_c;
      psum_vld_d = 1'b1;
    end
    if (ifmap_vld_q && sum_ovf_c) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ifmap_q     <= '0;
      ifmap_vld_q <= 1'b0;
      shadow_q    <= '0;
      active_q    <= '0;
      psum_q      <= '0;
      psum_vld_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      ifmap_q     <= ifmap_d;
      ifmap_vld_q <= ifmap_vld_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      psum_q      <= psum_d;
      psum_vld_q  <= psum_vld_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ifmap_out     = ifmap_q;
  assign ifmap_vld_out = ifmap_vld_q;
  assign wght_out      = shadow_q;
  assign psum_out      = psum_q;
  assign psum_vld_out  = psum_vld_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_mac_unit_dbw.sv
// Bench for mac_unit_dbw: saturating and wrapping instances share stimulus; an
// integer-arithmetic model feeds per-instance scoreboards drained by a monitor.
module tb_mac_unit_dbw;
  localparam int unsigned WD = 8;
  localparam int unsigned PW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [WD-1:0] ifmap_in, wght_in;
  logic          ifmap_vld_in, load_wght, swap_wght, clr_ovf;
  logic [PW-1:0] psum_in;

  logic [WD-1:0] s_ifmap_out, s_wght_out, w_ifmap_out, w_wght_out;
  logic          s_ifmap_vld_out, s_psum_vld_out, s_ovf;
  logic          w_ifmap_vld_out, w_psum_vld_out, w_ovf;
  logic [PW-1:0] s_psum_out, w_psum_out;

  mac_unit_dbw #(.WD(WD), .PW(PW), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .ifmap_in(ifmap_in), .ifmap_vld_in(ifmap_vld_in),
    .wght_in(wght_in), .load_wght(load_wght), .swap_wght(swap_wght),
    .psum_in(psum_in), .clr_ovf(clr_ovf), .ifmap_out(s_ifmap_out),
    .ifmap_vld_out(s_ifmap_vld_out), .wght_out(s_wght_out), .psum_out(s_psum_out),
    .psum_vld_out(s_psum_vld_out), .ovf(s_ovf));

  mac_unit_dbw #(.WD(WD), .PW(PW), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .ifmap_in(ifmap_in), .ifmap_vld_in(ifmap_vld_in),
    .wght_in(wght_in), .load_wght(load_wght), .swap_wght(swap_wght),
    .psum_in(psum_in), .clr_ovf(clr_ovf), .ifmap_out(w_ifmap_out),
    .ifmap_vld_out(w_ifmap_vld_out), .wght_out(w_wght_out), .psum_out(w_psum_out),
    .psum_vld_out(w_psum_vld_out), .ovf(w_ovf));

  int n_cmp = 0;
  int n_err = 0;
  int q_sat[$];
  int q_wrap[$];

  // Reference state as plain integers
  int m_shadow, m_active, m_if, m_ifv, m_psum_s, m_psum_w, m_pvld, m_ovf;

  function automatic int sx8(logic [7:0] x);
    return int'($signed(x));
  endfunction

  function automatic int sx16(logic [15:0] x);
    return int'($signed(x));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input logic [7:0] ifm, input bit ld,
                            input bit sw, input logic [7:0] w, input logic [15:0] ps,
                            input bit clr);
    int s, wr;
    bit ov;
    if (!r) begin
      m_shadow = 0; m_active = 0; m_if = 0; m_ifv = 0;
      m_psum_s = 0; m_psum_w = 0; m_pvld = 0; m_ovf = 0;
      return;
    end
    if (m_ifv != 0) begin
      s  = sx16(ps) + m_if * m_active;
      ov = (s > 32767) || (s < -32768);
      m_psum_s = ov ? ((s > 0) ? 32767 : -32768) : s;
      wr = ((s % 65536) + 65536) % 65536;
      if (wr > 32767) wr -= 65536;
      m_psum_w = wr;
      m_pvld = 1;
      q_sat.push_back(m_psum_s);
      q_wrap.push_back(m_psum_w);
      if (ov) m_ovf = 1;
      else if (clr) m_ovf = 0;
    end else begin
      m_pvld = 0;
      if (clr) m_ovf = 0;
    end
    if (sw) m_active = m_shadow;
    if (ld) m_shadow = sx8(w);
    m_if  = sx8(ifm);
    m_ifv = int'(v);
  endtask

  // One clock: drive at negedge, step the model, check registered state after the edge.
  task automatic drive(input bit r, input bit v, input logic [7:0] ifm, input bit ld,
                       input bit sw, input logic [7:0] w, input logic [15:0] ps,
                       input bit clr);
    rst = r; ifmap_vld_in = v; ifmap_in = ifm; load_wght = ld; swap_wght = sw;
    wght_in = w; psum_in = ps; clr_ovf = clr;
    model_edge(r, v, ifm, ld, sw, w, ps, clr);
    @(posedge clk);
    #1;
    chk("wght_out_sat", sx8(s_wght_out), m_shadow);
    chk("wght_out_wrap", sx8(w_wght_out), m_shadow);
    chk("ifmap_out", sx8(s_ifmap_out), m_if);
    chk("ifmap_vld_out", int'(s_ifmap_vld_out), m_ifv);
    chk("psum_vld_sat", int'(s_psum_vld_out), m_pvld);
    chk("psum_vld_wrap", int'(w_psum_vld_out), m_pvld);
    chk("ovf_sat", int'(s_ovf), m_ovf);
    chk("ovf_wrap", int'(w_ovf), m_ovf);
    if (m_pvld == 0) begin
      chk("psum_hold_sat", sx16(s_psum_out), m_psum_s);
      chk("psum_hold_wrap", sx16(w_psum_out), m_psum_w);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
  endtask

  // Scoreboard monitor: pop one expectation per presented result
  always @(negedge clk) begin
    if (s_psum_vld_out === 1'b1) begin
      if (q_sat.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sat_unexpected_valid: got psum %0d expected no result", sx16(s_psum_out));
      end else begin
        chk("psum_sat", sx16(s_psum_out), q_sat.pop_front());
      end
    end
    if (w_psum_vld_out === 1'b1) begin
      if (q_wrap.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL wrap_unexpected_valid: got psum %0d expected no result", sx16(w_psum_out));
      end else begin
        chk("psum_wrap", sx16(w_psum_out), q_wrap.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; ifmap_in = '0; ifmap_vld_in = 1'b0; wght_in = '0;
    load_wght = 1'b0; swap_wght = 1'b0; psum_in = '0; clr_ovf = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 16'h1234, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    chk("reset_psum", sx16(s_psum_out), 0);
    chk("reset_wght", sx8(s_wght_out), 0);

    // Basic chain: weight 3, ifmap 5, psum_in 10 -> 25
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd3, 16'h0000, 1'b0);
    chk("basic_wght_out", sx8(s_wght_out), 3);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b0);
    drive(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd10, 1'b0);
    chk("basic_psum", sx16(s_psum_out), 25);
    chk("basic_vld", int'(s_psum_vld_out), 1);

    // Overflow: -128*-128 + 32767
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b0);
    drive(1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h7FFF, 1'b0);
    chk("ovf_sat_psum", sx16(s_psum_out), 32767);
    chk("ovf_wrap_psum", sx16(w_psum_out), -16385);
    chk("ovf_flag", int'(s_ovf), 1);

    // Invalid cycles hold psum and ovf
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'($urandom), 1'b0);
    chk("hold_psum", sx16(s_psum_out), 32767);
    chk("hold_ovf", int'(s_ovf), 1);

    // Clear without overflow, then clear coinciding with overflow
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1);
    chk("clr_ovf", int'(s_ovf), 0);
    drive(1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h7FFF, 1'b1);
    chk("clr_vs_set_ovf", int'(s_ovf), 1);

    // Load+swap in the same cycle as a product: old active (2) used
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd2, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'd7, 16'h0000, 1'b0);
    drive(1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    drive(1'b1, 1'b1, 8'd1, 1'b1, 1'b1, 8'd9, 16'h0000, 1'b0);
    chk("swap_old_weight", sx16(s_psum_out), 8);
    chk("swap_wght_out", sx8(s_wght_out), 9);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    chk("swap_new_weight", sx16(s_psum_out), 7);

    // Mid-stream reset with valid result and ovf set
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'h0000, 1'b0);
    drive(1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    drive(1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 8'h00, 16'h7FFF, 1'b0);
    chk("pre_reset_vld", int'(s_psum_vld_out), 1);
    chk("pre_reset_ovf", int'(s_ovf), 1);
    drive(1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 8'h55, 16'h7FFF, 1'b1);
    chk("mid_reset_psum", sx16(s_psum_out), 0);
    chk("mid_reset_vld", int'(s_psum_vld_out), 0);
    chk("mid_reset_ovf", int'(s_ovf), 0);
    chk("mid_reset_wght", sx8(s_wght_out), 0);
    drive(1'b1, 1'b1, 8'd5, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd3, 1'b0);
    chk("post_reset_active0", sx16(s_psum_out), 3);

    // Randomized traffic biased toward extremes
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] ps;
      logic [7:0]  ifm, w;
      int sel;
      sel = int'($urandom_range(0, 3));
      ps  = (sel == 0) ? 16'h7FFF : (sel == 1) ? 16'h8000 : 16'($urandom);
      ifm = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
      w   = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), ifm,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), w, ps,
            ($urandom_range(0, 7) == 0));
    end

    idle(); idle(); idle();
    chk("sat_queue_drained", q_sat.size(), 0);
    chk("wrap_queue_drained", q_wrap.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_unit_dbw.md
MAC_UNIT_DBW -- requirements
Module: mac_unit_dbw

Interface
REQ-001 SHALL have parameter WD, default 8: ifmap/weight width, signed two's complement.
REQ-002 SHALL have parameter PW, default 2*WD: psum width; PW >= 2*WD, else elaboration error.
REQ-003 SHALL have parameter SAT, default 1: 1 = saturating accumulate, 0 = wrap-around.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-low (rst=0 at a rising edge resets).
REQ-006 ifmap_in  in  WD  signed activation from the upstream PE.
REQ-007 ifmap_vld_in  in  1  ifmap_in qualifier.
REQ-008 wght_in  in  WD  signed weight from the upstream PE (daisy chain).
REQ-009 load_wght  in  1  shift wght_in into the shadow weight register.
REQ-010 swap_wght  in  1  copy the shadow weight into the active weight register.
REQ-011 psum_in  in  PW  signed partial sum from the upstream row.
REQ-012 clr_ovf  in  1  clear the sticky overflow flag.
REQ-013 ifmap_out  out  WD  registered ifmap to the downstream PE.
REQ-014 ifmap_vld_out  out  1  registered ifmap_vld_in.
REQ-015 wght_out  out  WD  shadow weight register, to the next PE's wght_in.
REQ-016 psum_out  out  PW  registered accumulated sum.
REQ-017 psum_vld_out  out  1  psum_out qualifier.
REQ-018 ovf  out  1  sticky accumulate-overflow flag.

Function
REQ-019 SHALL register every cycle: ifmap_out<=ifmap_in, ifmap_vld_out<=ifmap_vld_in, with no enable.
REQ-020 SHALL, when load_wght=1, set shadow<=wght_in; otherwise shadow holds.
REQ-021 SHALL, when swap_wght=1, set active<=shadow (pre-edge value); otherwise active holds.
REQ-022 SHALL, with load_wght and swap_wght both 1, set active<=old shadow and shadow<=wght_in in the same edge.
REQ-023 SHALL compute product = ifmap_out * active as a 2*WD signed value, sign-extended to PW+1 bits.
REQ-024 SHALL compute sum = sext(psum_in, PW+1) + product; psum_in is aligned with ifmap_out (1-cycle systolic skew).
REQ-025 SHALL flag overflow when sum lies outside [-2^(PW-1), 2^(PW-1)-1].
REQ-026 SHALL, with SAT=1 and overflow, clamp the result to 2^(PW-1)-1 (positive) or -2^(PW-1) (negative).
REQ-027 SHALL, with SAT=0, take sum[PW-1:0] (wrap).
REQ-028 SHALL, when ifmap_vld_out=1, load psum_out with the result and set psum_vld_out=1 at the next edge.
REQ-029 SHALL, when ifmap_vld_out=0, hold psum_out and set psum_vld_out=0.
REQ-030 Latency: ifmap_in to ifmap_out is 1 cycle; ifmap_in to psum_out is 2 cycles.
REQ-031 SHALL use the pre-edge active weight for the product computed in a swap cycle; the new weight applies from the next cycle.
REQ-032 SHALL set ovf<=1 on any overflow with ifmap_vld_out=1, in both SAT modes.
REQ-033 SHALL, when clr_ovf=1 and no new overflow occurs, set ovf<=0; set wins when both occur in the same cycle.
REQ-034 SHALL ignore overflow while ifmap_vld_out=0.

Reset
REQ-035 SHALL, on rst=0 at an edge, zero ifmap_out, ifmap_vld_out, shadow/wght_out, active, psum_out, psum_vld_out and ovf, regardless of other inputs.
REQ-036 SHALL give reset priority over load_wght, swap_wght, clr_ovf and valid data in the same cycle; in-flight data is discarded.

Verification (WD=8, PW=16)
REQ-037 load_wght=1, wght_in=3 (edge 0); swap_wght=1 (edge 1); ifmap_in=5, vld=1 (edge 2); psum_in=10 (edge 3) -> psum_out=25, psum_vld_out=1 after edge 3; wght_out=3 after edge 0.
REQ-038 SAT=1, active=-128, ifmap=-128, psum_in=32767, vld -> psum_out=32767, ovf=1; SAT=0, same stimulus -> psum_out=-16385, ovf=1.
REQ-039 shadow=7, active=2, load_wght=1 and swap_wght=1 with wght_in=9, ifmap=4, vld, psum_in=0 -> that product uses 2 (psum_out=8); afterwards active=7, wght_out=9.
REQ-040 vld=0 for 3 cycles with changing psum_in -> psum_out unchanged, psum_vld_out=0, ovf unchanged.
REQ-041 ovf=1, clr_ovf=1 with no overflow -> ovf=0; clr_ovf=1 coinciding with an overflow -> ovf=1.
REQ-042 rst=0 for one edge mid-stream with psum_vld_out=1, ovf=1 -> all outputs 0 next cycle; the first post-reset product uses active=0.
